fifo_drain: RTL
===============

FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter FIFO_WIDTH, default 16: width of the FIFO read data and the stream data.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Asynchronous active-low reset.
REQ-004 en  input  1  Drain enable; high allows new FIFO reads.
REQ-005 empty  input  1  FIFO empty flag, sampled at rising edge.
REQ-006 data_out  input  FIFO_WIDTH  FIFO read data, valid one cycle after a sampled rd_en.
REQ-007 rd_en  output  1  FIFO read strobe, one word per cycle high.
REQ-008 m_data  output  FIFO_WIDTH  Stream output data.
REQ-009 m_valid  output  1  Stream output valid.
REQ-010 m_ready  input  1  Stream sink ready; a transfer occurs when m_valid and m_ready are both high at a rising edge.
REQ-011 busy  output  1  High whenever the state is not IDLE.

Function
REQ-012 rd_en SHALL be combinational: high only when state is RUN, empty is low, and (words in flight + words buffered) < 2.
REQ-013 A read issued at edge N SHALL capture data_out into the 2-entry output buffer at edge N+1, regardless of m_ready.
REQ-014 The output buffer SHALL be a 2-entry in-order skid buffer; m_data SHALL always present the oldest entry, with m_valid high iff the buffer is non-empty.
REQ-015 A capture and a pop in the same cycle SHALL both take effect; the buffer SHALL never overflow and SHALL never drop or reorder a word.
REQ-016 Once m_valid is high, m_data SHALL hold stable until the transfer occurs.
REQ-017 With m_ready held high and empty held low, throughput SHALL be one word per cycle after an initial 2-cycle latency (en high -> first m_valid).
REQ-018 FSM states: IDLE, RUN, FLUSH.
REQ-019 IDLE -> RUN when en is high; RUN -> FLUSH when en falls; FLUSH -> IDLE when no read is in flight and the buffer is empty; FLUSH -> RUN when en rises again.
REQ-020 In FLUSH, no new rd_en SHALL be issued, but in-flight and buffered words SHALL still be delivered.
REQ-021 The block SHALL never assert rd_en while empty is high.

Reset
REQ-022 On rst_n low, asynchronously: state=IDLE, buffer empty, in-flight cleared, m_valid=0, m_data=0, busy=0; rd_en then evaluates to 0.
REQ-023 Reset asserted mid-transfer SHALL discard all buffered and in-flight words; no word SHALL appear after reset release until a new read completes.

Configuration
REQ-024 With macro FIFO_DRAIN_STATS_EN defined, the block SHALL add outputs rd_count (16 bits, counts transfers on the stream, wraps 16'hFFFF -> 0) and underflow_err (sticky, set if rd_en is high while empty is high, cleared only by reset); both reset to 0.
REQ-025 Without FIFO_DRAIN_STATS_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 The FSM state enum (IDLE, RUN, FLUSH) and the FIFO_WIDTH default constant SHALL reside in shared_pkg.
REQ-027 The 2-entry skid buffer SHALL be a sub-module named drain_skid_buf; the FSM and read-credit logic stay in fifo_drain.

Verification
REQ-028 Reset, then en=1, m_ready=1, FIFO preloaded with 16'hA001..16'hA004 -> m_data A001..A004 on four consecutive cycles, first m_valid 2 cycles after en.
REQ-029 Preload 4 words, en=1, m_ready=0 for 10 cycles -> exactly 2 rd_en pulses, m_valid=1 with m_data=first word held stable; m_ready=1 -> remaining words delivered in order.
REQ-030 FIFO empty, en=1 for 20 cycles -> rd_en never high, m_valid=0, busy=1.
REQ-031 Drop en while 2 words are buffered -> state FLUSH, no further rd_en, both words delivered, then busy=0.
REQ-032 Assert rst_n=0 while m_valid=1 -> m_valid=0 immediately; after release, no stale word is delivered.
REQ-033 With FIFO_DRAIN_STATS_EN, deliver 5 words -> rd_count=5, underflow_err=0.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared definitions for the FIFO drain block: the default data width, the drain
// FSM state encoding and the read-credit helper.
package shared_pkg;

  localparam int unsigned DEFAULT_FIFO_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

  // A new read may issue only if it will find a free slot when it lands one cycle later.
  // A word popped this cycle already frees its slot, so it is subtracted here.
  function automatic logic read_ok(input logic in_flight, input logic [1:0] count,
                                   input logic pop);
    logic [2:0] occ;
    occ = {2'b00, in_flight} + {1'b0, count} - {2'b00, pop};
    return occ < 3'd2;
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry in-order skid buffer. The head entry drives the stream output and only
// changes when it is popped or when the buffer is empty, so data stays stable while
// valid is waiting on ready.
module drain_skid_buf
  import shared_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [1:0]       count,
  output logic             pop
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  // Next-state for the two entries; push and pop in the same cycle both take effect.
  always_comb begin
    pop     = ready && (count_q != 2'd0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign data  = head_q;
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/fifo_drain.sv
// Drains a FIFO with a one-cycle read latency into a valid/ready stream.
// Optional statistics (transfer counter, sticky underflow flag) are built when
// FIFO_DRAIN_STATS_EN is defined.
module fifo_drain
  import shared_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEFAULT_FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic                  underflow_err
`endif
);

  drain_state_e state_q, state_d;
  logic         in_flight_q;
  logic [1:0]   buf_count;
  logic         buf_pop;

  drain_skid_buf #(
    .WIDTH(FIFO_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_flight_q),
    .push_data(data_out),
    .ready    (m_ready),
    .data     (m_data),
    .valid    (m_valid),
    .count    (buf_count),
    .pop      (buf_pop)
  );

  // Read strobe: only while running and enabled, never into an empty FIFO, and only
  // when a buffer slot is guaranteed for the returning word.
  always_comb begin
    rd_en = (state_q == RUN) && en && !empty && read_ok(in_flight_q, buf_count, buf_pop);
  end

  // Drain FSM next state; re-enabling during FLUSH resumes reads immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = FLUSH;
      FLUSH: begin
        if (en)                                         state_d = RUN;
        else if (!in_flight_q && (buf_count == 2'd0))   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and the one-deep read-in-flight tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= rd_en;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef FIFO_DRAIN_STATS_EN
  // Stream transfer counter (wraps) and sticky read-while-empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count      <= 16'd0;
      underflow_err <= 1'b0;
    end else begin
      if (buf_pop)         rd_count      <= rd_count + 16'd1;
      if (rd_en && empty)  underflow_err <= 1'b1;
    end
  end
`endif

endmodule
